// File: rtl/count_pwm_gen.sv
// count_pwm_gen: registered PWM driven by an upstream free-running count.
// The duty is taken in through a valid/ready shadow register and applied only
// at the count wrap (max -> 0), so no period ever sees a partial duty change.
// A one-cycle wrap pulse marks each period boundary.
// Optional feature macro: PWM_WRAP_IRQ_EN adds irq/irq_clr, a sticky flag set on
// every wrap that applies a new duty.
module count_pwm_gen #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             wrap_pulse,
`ifdef PWM_WRAP_IRQ_EN
  input  logic             irq_clr,
  output logic             irq,
`endif
  output logic [WIDTH-1:0] duty_active
);

  logic [WIDTH-1:0] prev_count_q;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             pending_q, pending_d;
  logic             pwm_q, pwm_d;
  logic             wrap_q;
  logic             wrap;
  logic             accept;
  logic             xfer;

  // Wrap detection, handshake and next-state for shadow/active/pending
  always_comb begin
    wrap      = (prev_count_q == {WIDTH{1'b1}}) && (count == '0);
    accept    = duty_valid && !pending_q;
    xfer      = wrap && pending_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (xfer) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (accept) begin
      // A capture on a wrap with nothing pending waits for the next wrap
      shadow_d  = duty_in;
      pending_d = 1'b1;
    end
    // Compare against the duty taking effect this edge so the count=0 sample
    // of a new period already uses the new duty
    pwm_d = (count < active_d);
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_count_q <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      pwm_q        <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      prev_count_q <= count;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pwm_q        <= pwm_d;
      wrap_q       <= wrap;
    end
  end

`ifdef PWM_WRAP_IRQ_EN
  logic irq_q;

  // Sticky transfer flag; clear wins over a same-cycle set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end else if (xfer) begin
      irq_q <= 1'b1;
    end
  end

  assign irq = irq_q;
`endif

  assign duty_ready  = !pending_q;
  assign pwm_out     = pwm_q;
  assign wrap_pulse  = wrap_q;
  assign duty_active = active_q;

endmodule

// File: tb/tb_count_pwm_gen.sv
// Self-checking bench for count_pwm_gen: directed period scenarios followed by
// randomized duty offers, count jumps and resets, all against a reference model.
module tb_count_pwm_gen;

  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] count;
  logic [W-1:0] duty_in;
  logic         duty_valid;
  logic         duty_ready;
  logic         pwm_out;
  logic         wrap_pulse;
  logic [W-1:0] duty_active;
`ifdef PWM_WRAP_IRQ_EN
  logic         irq_clr;
  logic         irq;
`endif

  count_pwm_gen #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .count      (count),
    .duty_in    (duty_in),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .pwm_out    (pwm_out),
    .wrap_pulse (wrap_pulse),
`ifdef PWM_WRAP_IRQ_EN
    .irq_clr    (irq_clr),
    .irq        (irq),
`endif
    .duty_active(duty_active)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: what the spec says the block holds
  int m_prev, m_shadow, m_active;
  bit m_pending, m_pwm, m_wrap, m_irq;

  int cnt;      // next count value the upstream counter presents
  int pwm_hi;   // pwm high samples seen in the current window
  int wraps;    // wrap pulses seen in the current window
  bit clr_req;  // irq_clr to drive on the next step

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_prev = 0; m_shadow = 0; m_active = 0;
    m_pending = 0; m_pwm = 0; m_wrap = 0; m_irq = 0;
  endtask

  // One clock: present cnt, optionally offer a duty, advance model, compare
  task automatic step(input bit vld, input int d);
    bit w, xfer;
    @(negedge clk);
    count      = cnt[W-1:0];
    duty_valid = vld;
    duty_in    = d[W-1:0];
`ifdef PWM_WRAP_IRQ_EN
    irq_clr    = clr_req;
`endif
    check_val("duty_ready", 32'(duty_ready), 32'(!m_pending));
    @(posedge clk);
    w    = (m_prev == MAX) && (cnt == 0);
    xfer = w && m_pending;
    if (xfer) begin
      m_active  = m_shadow;
      m_pending = 0;
    end else if (vld && !m_pending) begin
      m_shadow  = d;
      m_pending = 1;
    end
    if (clr_req) m_irq = 0;
    else if (xfer) m_irq = 1;
    m_pwm  = (cnt < m_active);
    m_wrap = w;
    m_prev = cnt;
    #1;
    check_val("pwm_out", 32'(pwm_out), 32'(m_pwm));
    check_val("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
    check_val("duty_active", 32'(duty_active), 32'(m_active));
`ifdef PWM_WRAP_IRQ_EN
    check_val("irq", 32'(irq), 32'(m_irq));
`endif
    if (pwm_out) pwm_hi++;
    if (wrap_pulse) wraps++;
    cnt     = (cnt + 1) % (MAX + 1);
    clr_req = 0;
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i <= MAX + 1 && cnt != target; i++) step(0, 0);
  endtask

  // Assert reset mid-cycle; outputs must clear before any clock edge
  task automatic do_reset();
    @(negedge clk);
    count = cnt[W-1:0];
    reset = 1'b1;
    #1;
    model_clear();
    check_val("rst_pwm", 32'(pwm_out), 32'(0));
    check_val("rst_wrap", 32'(wrap_pulse), 32'(0));
    check_val("rst_active", 32'(duty_active), 32'(0));
    check_val("rst_ready", 32'(duty_ready), 32'(1));
`ifdef PWM_WRAP_IRQ_EN
    check_val("rst_irq", 32'(irq), 32'(0));
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; count = '0; duty_in = '0; duty_valid = 1'b0; clr_req = 0;
`ifdef PWM_WRAP_IRQ_EN
    irq_clr = 1'b0;
`endif
    model_clear();
    cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_ready", 32'(duty_ready), 32'(1));
    check_val("reset_pwm", 32'(pwm_out), 32'(0));
    reset = 1'b0;

    // No duty offered: pwm stays low, exactly one wrap pulse per period
    wraps = 0; pwm_hi = 0;
    repeat (MAX + 2) step(0, 0);
    check_val("idle_wraps", 32'(wraps), 32'(1));
    check_val("idle_high", 32'(pwm_hi), 32'(0));

    // Duty 64 offered at count 10, applied at the next wrap
    run_to(10);
    step(1, 64);
    check_val("d64_ready", 32'(duty_ready), 32'(0));
    run_to(0);
    check_val("d64_hold", 32'(duty_active), 32'(0));
    pwm_hi = 0;
    repeat (MAX + 1) step(0, 0);
    check_val("d64_high", 32'(pwm_hi), 32'(64));
    check_val("d64_active", 32'(duty_active), 32'(64));

    // Duty 255, then 3 offered while pending must be ignored
    run_to(20);
    step(1, 255);
    step(1, 3);
    step(1, 3);
    run_to(0);
    pwm_hi = 0;
    repeat (MAX + 1) step(0, 0);
    check_val("d255_high", 32'(pwm_hi), 32'(255));
    check_val("d255_active", 32'(duty_active), 32'(255));

    // Handshake on the wrap cycle itself: applies only at the following wrap
    step(1, 128);
    check_val("wrapcap_old", 32'(duty_active), 32'(255));
    check_val("wrapcap_pend", 32'(duty_ready), 32'(0));
    run_to(0);
    step(0, 0);
    check_val("wrapcap_new", 32'(duty_active), 32'(128));

    // Upstream restart 100 -> 0 with duty pending is not a wrap
    run_to(90);
    step(1, 50);
    run_to(101);
    cnt = 0;
    step(0, 0);
    check_val("jump_wrap", 32'(wrap_pulse), 32'(0));
    check_val("jump_pend", 32'(duty_ready), 32'(0));
    check_val("jump_active", 32'(duty_active), 32'(128));

    // Reset at count 200 with a duty pending
    run_to(200);
`ifdef PWM_WRAP_IRQ_EN
    check_val("irq_before_rst", 32'(irq), 32'(1));
`endif
    do_reset();
    step(0, 0);
    check_val("post_rst_ready", 32'(duty_ready), 32'(1));
`ifdef PWM_WRAP_IRQ_EN
    // Transfer sets irq; a one-cycle clear drops it
    step(1, 77);
    run_to(0);
    step(0, 0);
    check_val("irq_set", 32'(irq), 32'(1));
    clr_req = 1;
    step(0, 0);
    check_val("irq_clr", 32'(irq), 32'(0));
`endif

    // Randomized traffic: sparse offers, occasional jumps, clears and resets
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 399) == 0) cnt = int'($urandom_range(0, MAX));
      if ($urandom_range(0, 99) == 0) clr_req = 1;
      if ($urandom_range(0, 2999) == 0) do_reset();
      else step($urandom_range(0, 29) == 0, int'($urandom_range(0, MAX)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
